// File: rtl/pcie_s10_msi_irq_pkg.sv
// Shared types for the MSI interrupt controller.
// Holds the handshake FSM state encoding used by pcie_s10_msi_irq.
package pcie_s10_msi_irq_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } msi_state_e;

endpackage

// File: rtl/pcie_s10_msi_rr_select.sv
// Combinational round-robin first-set search.
// Returns the first set bit of req at or after ptr, wrapping around.
//   req   : request vector, one bit per candidate
//   ptr   : start position of the search
//   idx   : index of the winning candidate (0 when none)
//   valid : at least one request bit is set
module pcie_s10_msi_rr_select #(
    parameter int IDX_W = 5
) (
    input  logic [(2**IDX_W)-1:0] req,
    input  logic [IDX_W-1:0]      ptr,
    output logic [IDX_W-1:0]      idx,
    output logic                  valid
);

    localparam int N = 2**IDX_W;

    logic [IDX_W-1:0] cand;

    // Walk offsets from farthest to nearest so the nearest set bit is the
    // last one written and therefore wins. The IDX_W-bit add wraps mod N.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        cand  = '0;
        for (int i = N - 1; i >= 0; i--) begin
            cand = ptr + IDX_W'(i);
            if (req[cand]) begin
                idx   = cand;
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pcie_s10_msi_irq.sv
// Multi-vector MSI interrupt controller for the Stratix 10 hard IP.
// Events set per-vector pending bits (duplicates coalesce); eligible vectors
// (pending, unmasked, MSI enabled) are served round-robin over the
// app_msi_req/app_msi_ack handshake, with optional ack timeout and retry.
//   clk, rst             : clock, synchronous active-high reset
//   irq_index/irq_valid  : event input, one per cycle; irq_ready always 1
//   msi_enable/msi_mask  : configuration-space enable and per-vector mask
//   msi_func_num         : PF number, captured at request start
//   app_msi_*            : hard IP MSI request interface (all registered)
//   status_pending       : pending bitmap
//   status_timeout_count : saturating count of ack timeouts
module pcie_s10_msi_irq
    import pcie_s10_msi_irq_pkg::*;
#(
    parameter int IRQ_INDEX_WIDTH = 5,
    parameter int MSI_TC          = 0,
    parameter int ACK_TIMEOUT     = 0
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [IRQ_INDEX_WIDTH-1:0]      irq_index,
    input  logic                            irq_valid,
    output logic                            irq_ready,
    input  logic                            msi_enable,
    input  logic [(2**IRQ_INDEX_WIDTH)-1:0] msi_mask,
    input  logic [1:0]                      msi_func_num,
    output logic                            app_msi_req,
    input  logic                            app_msi_ack,
    output logic [2:0]                      app_msi_tc,
    output logic [4:0]                      app_msi_num,
    output logic [1:0]                      app_msi_func_num,
    output logic [(2**IRQ_INDEX_WIDTH)-1:0] status_pending,
    output logic [15:0]                     status_timeout_count
);

    localparam int IRQ_COUNT = 2**IRQ_INDEX_WIDTH;
    localparam int CNT_W     = $clog2(ACK_TIMEOUT + 2);

    msi_state_e                 state, state_nxt;
    logic [IRQ_COUNT-1:0]       pending, pending_nxt, eligible;
    logic [IRQ_INDEX_WIDTH-1:0] rr_ptr, sel_q, sel_idx;
    logic                       sel_vld;
    logic [CNT_W-1:0]           wait_cnt;
    logic                       start, ack_done, to_done;

    assign eligible = msi_enable ? (pending & ~msi_mask) : '0;

    pcie_s10_msi_rr_select #(
        .IDX_W (IRQ_INDEX_WIDTH)
    ) u_rr_select (
        .req   (eligible),
        .ptr   (rr_ptr),
        .idx   (sel_idx),
        .valid (sel_vld)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start)               state_nxt = ST_REQ;
            ST_REQ:  if (ack_done || to_done) state_nxt = ST_IDLE;
            default:                          state_nxt = ST_IDLE;
        endcase
    end

    // Handshake event decode. Ack in the final wait cycle beats the timeout.
    always_comb begin
        start    = (state == ST_IDLE) && sel_vld;
        ack_done = (state == ST_REQ) && app_msi_ack;
        to_done  = (state == ST_REQ) && (ACK_TIMEOUT != 0) && !app_msi_ack &&
                   (wait_cnt == CNT_W'(ACK_TIMEOUT));
    end

    // Sets are applied after clears so a new event always survives selection
    // or a coinciding timeout re-set.
    always_comb begin
        pending_nxt = pending;
        if (start)     pending_nxt[sel_idx]   = 1'b0;
        if (to_done)   pending_nxt[sel_q]     = 1'b1;
        if (irq_valid) pending_nxt[irq_index] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending              <= '0;
            rr_ptr               <= '0;
            sel_q                <= '0;
            wait_cnt             <= '0;
            app_msi_func_num     <= '0;
            status_timeout_count <= '0;
            irq_ready            <= 1'b0;
        end else begin
            irq_ready <= 1'b1;
            pending   <= pending_nxt;
            if (start) begin
                sel_q            <= sel_idx;
                app_msi_func_num <= msi_func_num;
            end
            if (ack_done) rr_ptr <= sel_q + 1'b1;
            if (to_done && status_timeout_count != 16'hFFFF)
                status_timeout_count <= status_timeout_count + 16'd1;
            if (state == ST_REQ && !(ack_done || to_done))
                wait_cnt <= wait_cnt + 1'b1;
            else
                wait_cnt <= '0;
        end
    end

    assign app_msi_req    = (state == ST_REQ);
    assign app_msi_num    = 5'(sel_q);
    assign app_msi_tc     = 3'(MSI_TC);
    assign status_pending = pending;

endmodule
